// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, access owner, read-latency bound.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between fetch and data requesters (0 cycles, no state).
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data always beats fetch.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      // On a tie, whoever did not win last time goes first.
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_D);

  always_comb begin
    winner = d_req ? OWN_D : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants one fetch/data access at a time to a sync-read RAM; store ack 1 cycle, read data RD_LAT+1 after grant.
// Requests are held until gnt (issued only in IDLE); MEM_ARB_RR_EN enables round-robin tie-break in arb_pick.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W     = $clog2(RD_LAT_MAX);
  localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            owner_q;
  owner_t            winner;
  logic              we_q;
  logic              grant;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // owner_q doubles as the round-robin history: it changes exactly at each grant.
  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (owner_q),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    ram_w_en  = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_w_en = we_q;
        if (we_q) begin
          // Stores only come from the data side; acknowledge as the write happens.
          d_rvalid = 1'b1;
          state_d  = IDLE;
        end else if (RD_LAT == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_INIT);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      we_q       <= 1'b0;
      owner_q    <= OWN_D;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant) begin
        owner_q <= winner;
        if (winner == OWN_D) begin
          ram_addr  <= d_addr;
          ram_wdata <= d_wdata;
          we_q      <= d_we;
        end else begin
          ram_addr <= if_addr;
          we_q     <= 1'b0;
        end
      end
      if (state_q == RESP) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= ram_rdata;
        end else begin
          d_rdata_q <= ram_rdata;
        end
      end
    end
  end

  assign if_gnt   = rst_n && grant && (winner == OWN_IF);
  assign d_gnt    = rst_n && grant && (winner == OWN_D);
  assign busy     = (state_q != IDLE);
  assign if_rdata = (state_q == RESP && owner_q == OWN_IF) ? ram_rdata : if_rdata_q;
  assign d_rdata  = (state_q == RESP && owner_q == OWN_D) ? ram_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 1-cycle-latency and a 3-cycle-latency arbiter, each with its own RAM model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  logic pre_en;
  logic [10:0] pre_addr;
  logic [31:0] pre_dat;

  logic a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid, a_ram_w_en, a_busy;
  logic [10:0] a_if_addr, a_d_addr, a_ram_addr;
  logic [31:0] a_if_rdata, a_d_wdata, a_d_rdata, a_ram_wdata, a_ram_rdata;

  logic b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid, b_ram_w_en, b_busy;
  logic [10:0] b_if_addr, b_d_addr, b_ram_addr;
  logic [31:0] b_if_rdata, b_d_wdata, b_d_rdata, b_ram_wdata, b_ram_rdata;

  logic [31:0] a_mem [0:2047];
  logic [31:0] b_mem [0:2047];
  logic [31:0] b_p0, b_p1;

  int checks;
  int errors;
  logic first_d;
  logic saw_rv;

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_w_en(a_ram_w_en),
    .ram_rdata(a_ram_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_w_en(b_ram_w_en),
    .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: read data appears RD_LAT edges after the address is presented.
  always @(posedge clk) begin
    if (pre_en) a_mem[pre_addr] <= pre_dat;
    else if (a_ram_w_en) a_mem[a_ram_addr] <= a_ram_wdata;
    a_ram_rdata <= a_mem[a_ram_addr];
  end

  always @(posedge clk) begin
    if (pre_en) b_mem[pre_addr] <= pre_dat;
    else if (b_ram_w_en) b_mem[b_ram_addr] <= b_ram_wdata;
    b_p0        <= b_mem[b_ram_addr];
    b_p1        <= b_p0;
    b_ram_rdata <= b_p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    rst_n = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
    a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
    #1;
    rst_n = 1'b0;
    a_if_req = 1'b1;
    b_d_req  = 1'b1;
    #1;
    check("rst_if_gnt",    32'(a_if_gnt), 32'd0);
    check("rst_d_gnt",     32'(b_d_gnt), 32'd0);
    check("rst_busy",      32'(a_busy), 32'd0);
    check("rst_ram_addr",  32'(a_ram_addr), 32'd0);
    check("rst_ram_w_en",  32'(a_ram_w_en), 32'd0);
    check("rst_ram_wdata", a_ram_wdata, 32'd0);
    check("rst_if_rvalid", 32'(a_if_rvalid), 32'd0);
    check("rst_d_rvalid",  32'(a_d_rvalid), 32'd0);
    check("rst_if_rdata",  a_if_rdata, 32'd0);
    check("rst_d_rdata",   a_d_rdata, 32'd0);
    a_if_req = 1'b0;
    b_d_req  = 1'b0;

    pre_en = 1'b1; pre_addr = 11'h010; pre_dat = 32'hE3A01005;
    step;
    pre_addr = 11'h020; pre_dat = 32'h12345678;
    step;
    pre_en = 1'b0;
    rst_n = 1'b1;

    // Fetch on the RD_LAT=1 arbiter
    step; a_if_req = 1'b1; a_if_addr = 11'h010; #1;
    check("fetch_gnt_c0",   32'(a_if_gnt), 32'd1);
    check("fetch_busy_c0",  32'(a_busy), 32'd0);
    step; a_if_req = 1'b0; #1;
    check("fetch_ram_addr_c1", 32'(a_ram_addr), 32'h010);
    check("fetch_busy_c1",     32'(a_busy), 32'd1);
    check("fetch_rvalid_c1",   32'(a_if_rvalid), 32'd0);
    step; #1;
    check("fetch_rvalid_c2", 32'(a_if_rvalid), 32'd1);
    check("fetch_rdata_c2",  a_if_rdata, 32'hE3A01005);
    check("fetch_busy_c2",   32'(a_busy), 32'd1);
    step; #1;
    check("fetch_busy_c3",   32'(a_busy), 32'd0);
    check("fetch_rvalid_c3", 32'(a_if_rvalid), 32'd0);
    check("fetch_rdata_hold", a_if_rdata, 32'hE3A01005);

    // Store then load back
    step; a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 11'h100; a_d_wdata = 32'hDEADBEEF; #1;
    check("st_d_gnt",  32'(a_d_gnt), 32'd1);
    check("st_if_gnt", 32'(a_if_gnt), 32'd0);
    step; a_d_req = 1'b0; a_d_we = 1'b0; #1;
    check("st_w_en_c1",  32'(a_ram_w_en), 32'd1);
    check("st_ack_c1",   32'(a_d_rvalid), 32'd1);
    check("st_addr_c1",  32'(a_ram_addr), 32'h100);
    check("st_wdata_c1", a_ram_wdata, 32'hDEADBEEF);
    step; #1;
    check("st_w_en_c2", 32'(a_ram_w_en), 32'd0);
    check("st_ack_c2",  32'(a_d_rvalid), 32'd0);
    check("st_busy_c2", 32'(a_busy), 32'd0);
    a_d_req = 1'b1; a_d_addr = 11'h100; #1;
    check("ld_d_gnt", 32'(a_d_gnt), 32'd1);
    step; a_d_req = 1'b0; #1;
    check("ld_rvalid_c1", 32'(a_d_rvalid), 32'd0);
    check("ld_w_en_c1",   32'(a_ram_w_en), 32'd0);
    step; #1;
    check("ld_rvalid_c2", 32'(a_d_rvalid), 32'd1);
    check("ld_rdata_c2",  a_d_rdata, 32'hDEADBEEF);

    // First tie: loser withdraws before being granted
    step; a_if_req = 1'b1; a_if_addr = 11'h010; a_d_req = 1'b1; a_d_addr = 11'h020; #1;
    check("tie1_d_gnt",  32'(a_d_gnt), 32'(first_d));
    check("tie1_if_gnt", 32'(a_if_gnt), 32'(!first_d));
    step; a_if_req = 1'b0; a_d_req = 1'b0; #1;
    step; #1;
    check("tie1_d_rvalid",  32'(a_d_rvalid), 32'(first_d));
    check("tie1_if_rvalid", 32'(a_if_rvalid), 32'(!first_d));

    // Second tie: data wins, fetch waits until the next IDLE
    step; a_if_req = 1'b1; a_d_req = 1'b1; #1;
    check("tie2_d_gnt",  32'(a_d_gnt), 32'd1);
    check("tie2_if_gnt", 32'(a_if_gnt), 32'd0);
    step; a_d_req = 1'b0; #1;
    check("tie2_if_gnt_busy", 32'(a_if_gnt), 32'd0);
    step; #1;
    check("tie2_d_rvalid", 32'(a_d_rvalid), 32'd1);
    check("tie2_d_rdata",  a_d_rdata, 32'h12345678);
    check("tie2_if_gnt_resp", 32'(a_if_gnt), 32'd0);
    step; #1;
    check("tie2_if_gnt_idle", 32'(a_if_gnt), 32'd1);
    step; a_if_req = 1'b0; #1;
    step; #1;
    check("tie2_if_rvalid", 32'(a_if_rvalid), 32'd1);
    check("tie2_if_rdata",  a_if_rdata, 32'hE3A01005);

    // RD_LAT=3 load; fetch arrives while busy
    step; b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 11'h020; #1;
    check("l3_d_gnt", 32'(b_d_gnt), 32'd1);
    step; b_d_req = 1'b0; b_if_req = 1'b1; b_if_addr = 11'h010; #1;
    for (int i = 1; i <= 3; i++) begin
      check("l3_no_rvalid", 32'(b_d_rvalid), 32'd0);
      check("l3_no_gnt",    32'(b_if_gnt), 32'd0);
      check("l3_addr_hold", 32'(b_ram_addr), 32'h020);
      check("l3_busy",      32'(b_busy), 32'd1);
      step; #1;
    end
    check("l3_d_rvalid", 32'(b_d_rvalid), 32'd1);
    check("l3_d_rdata",  b_d_rdata, 32'h12345678);
    check("l3_if_gnt_resp", 32'(b_if_gnt), 32'd0);
    step; #1;
    check("l3_if_gnt_idle", 32'(b_if_gnt), 32'd1);
    step; b_if_req = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("l3_if_no_rvalid", 32'(b_if_rvalid), 32'd0);
      step; #1;
    end
    check("l3_if_rvalid", 32'(b_if_rvalid), 32'd1);
    check("l3_if_rdata",  b_if_rdata, 32'hE3A01005);

    // Reset pulse during WAIT aborts the access
    step; b_if_req = 1'b1; b_if_addr = 11'h010; #1;
    check("rm_if_gnt", 32'(b_if_gnt), 32'd1);
    step; b_if_req = 1'b0; #1;
    step; #1;
    check("rm_busy_wait", 32'(b_busy), 32'd1);
    b_d_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rm_busy",      32'(b_busy), 32'd0);
    check("rm_ram_addr",  32'(b_ram_addr), 32'd0);
    check("rm_if_rdata",  b_if_rdata, 32'd0);
    check("rm_d_rdata",   b_d_rdata, 32'd0);
    check("rm_d_gnt",     32'(b_d_gnt), 32'd0);
    check("rm_if_rvalid", 32'(b_if_rvalid), 32'd0);
    #1;
    b_d_req = 1'b0;
    rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step; #1;
      saw_rv = saw_rv | b_if_rvalid | b_d_rvalid;
    end
    check("rm_no_rvalid", 32'(saw_rv), 32'd0);
    b_d_req = 1'b1; b_d_addr = 11'h020; #1;
    check("rm_new_gnt", 32'(b_d_gnt), 32'd1);
    step; b_d_req = 1'b0;
    step; step; step; #1;
    check("rm_new_rvalid", 32'(b_d_rvalid), 32'd1);
    check("rm_new_rdata",  b_d_rdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single synchronous-read RAM port between the instruction-fetch requester and the data requester (the LDR/STR memory stage) of the multicycle ARM32 core. It grants one access at a time, drives the RAM address, write data and write enable, and returns read data with a one-cycle valid pulse. The controller FSM waits on the valid pulses instead of fixed fetch_wait and memory_wait stalls.

Parameters:
ADDR_W, 11, RAM word-address width
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch grant pulse
if_rvalid  out  1  fetch data valid pulse
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data grant pulse
d_rvalid  out  1  load data valid pulse, or store acknowledge
d_rdata  out  DATA_W  load data
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_w_en  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
- Reset values: state IDLE; ram_addr, ram_wdata, if_rdata, d_rdata = 0; ram_w_en, both gnt, both rvalid, busy = 0.
- While rst_n is low, both gnt outputs are forced to 0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is present, pick a winner and pulse its gnt combinationally in that same cycle (T).
  - At the clock edge, register addr, we, wdata and owner into the ram_* outputs, then go to ACCESS.
  - A requester may drop req before it is granted; there is no penalty.
- ACCESS (T+1):
  - ram_addr is valid; ram_w_en = latched we.
  - Store: pulse d_rvalid (ack) this cycle, then go to IDLE. Store acknowledge latency is 1.
  - Load/fetch: if RD_LAT = 1, go to RESP; otherwise go to WAIT with a counter loaded with RD_LAT-2.
- WAIT: decrement the counter; go to RESP when it reaches 0. ram_addr is held; ram_w_en = 0.
- RESP (T+1+RD_LAT):
  - Pulse the owner's rvalid.
  - The owner's rdata register captures ram_rdata at this edge and also passes it through combinationally during RESP.
  - rdata holds its last value afterwards.
  - Next state is IDLE.
- Only one access is outstanding at a time. No grant is issued outside IDLE; requests arriving meanwhile wait.
- Throughput: one read per RD_LAT+2 cycles; one write per 2 cycles.
- Default arbitration is fixed priority: data beats fetch when both requests are high in the same IDLE cycle.
- A fetch request with d_we is impossible by construction: fetch is always a read.
- Reset asserted mid-access: state returns to IDLE immediately; no rvalid is issued; ram_w_en drops asynchronously. Requesters must re-request.
- Addresses wider than ADDR_W are truncated by the requester; the arbiter does no bounds checking.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner register (reset = DATA, so fetch wins the first tie) updates at every grant. On a tie, the requester that was not last_owner wins. Single requesters are always granted.
- Undefined: fixed data-over-fetch priority; no last_owner register.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum {IDLE, ACCESS, WAIT, RESP}
  - owner_t enum {OWN_IF, OWN_D}
  - constant RD_LAT_MAX = 4
- One sub-module, arb_pick: combinational winner select taking if_req, d_req and last_owner, producing the winner. The `ifdef MEM_ARB_RR_EN lives only inside arb_pick.

Test Plan:
- Fetch only, RD_LAT=1, RAM[0x010]=0xE3A01005, if_req with if_addr=0x010 at cycle 0:
  - if_gnt pulses at cycle 0; ram_addr=0x010 at cycle 1; if_rvalid=1 with if_rdata=0xE3A01005 at cycle 2; busy=1 for cycles 1-2.
- Store, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF:
  - d_gnt at cycle 0; ram_w_en=1 and d_rvalid=1 at cycle 1 only.
  - A following load of 0x100 returns 0xDEADBEEF.
- Tie, if_req and d_req both high at cycle 0, default build:
  - d_gnt first; if_gnt in the IDLE cycle after the data RESP.
  - With MEM_ARB_RR_EN: the first tie grants fetch and the second tie grants data.
- RD_LAT=3 load of 0x020:
  - rvalid exactly 4 cycles after gnt; ram_addr stable through WAIT; no grant issued while busy.
- Reset mid-operation: rst_n pulsed low during WAIT:
  - all outputs return to reset values at once; no rvalid is ever seen for the aborted access; a new request is granted normally afterwards.
